uart_tx: RTL and testbench

Serial transmitter for the cipher datapath. It takes one DBIT-wide byte per request and shifts it out on `tx` as an asynchronous frame: start bit, data LSB-first, optional parity, then stop. Bit timing comes from an external oversampling tick (16 ticks per bit) produced by the top-level baud-rate counter. It sits between the XOR cipher output and the board TX pin, mirroring the receive path.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_tx.sv | 158 +++++++++++++++
 tb/tb_uart_tx.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmit and receive paths: frame FSM states,
// the oversampling ratio and the default frame geometry.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int OVERSAMPLE      = 16;
    localparam int DEFAULT_DBIT    = 8;
    localparam int DEFAULT_SB_TICK = 16;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB-first, optional even parity, stop.
// Define UART_TX_PARITY_EN to insert the parity bit between the data and stop bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DBIT    = DEFAULT_DBIT,
    parameter int SB_TICK = DEFAULT_SB_TICK
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_tick,
    input  logic            tx_start,
    input  logic [DBIT-1:0] din,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    localparam int SW = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : $clog2(OVERSAMPLE);
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [SW-1:0] BIT_LAST  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] STOP_LAST = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);

    uart_state_e     state_q, state_d;
    logic [SW-1:0]   s_cnt_q, s_cnt_d;
    logic [NW-1:0]   n_cnt_q, n_cnt_d;
    logic [DBIT-1:0] b_q,     b_d;
    logic            tx_q,    tx_d;
    logic            busy_q,  busy_d;
    logic            done_c;
`ifdef UART_TX_PARITY_EN
    logic            par_q,   par_d;
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d = state_q;
        s_cnt_d = s_cnt_q;
        n_cnt_d = n_cnt_q;
        b_d     = b_q;
        done_c  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif

        case (state_q)
            IDLE: begin
                if (tx_start) begin
                    b_d     = din;
                    s_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^din;
`endif
                    state_d = START;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_cnt_q == BIT_LAST) begin
                        s_cnt_d = '0;
                        n_cnt_d = '0;
                        state_d = DATA;
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_cnt_q == BIT_LAST) begin
                        s_cnt_d = '0;
                        b_d     = b_q >> 1;
                        if (n_cnt_q == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            n_cnt_d = n_cnt_q + 1'b1;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (s_cnt_q == BIT_LAST) begin
                        s_cnt_d = '0;
                        state_d = STOP;
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (s_cnt_q == STOP_LAST) begin
                        s_cnt_d = '0;
                        done_c  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is registered from the next state so the pin changes on the same edge as the FSM.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = b_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q <= IDLE;
            s_cnt_q <= '0;
            n_cnt_q <= '0;
            b_q     <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_cnt_q <= s_cnt_d;
            n_cnt_q <= n_cnt_d;
            b_q     <= b_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // The done pulse must coincide with the final tick, so it is decoded rather than registered.
    assign tx_done_tick = done_c & ~rst;
    assign tx           = tx_q;
    assign tx_busy      = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a tick-position frame model is compared every cycle,
// plus hand-computed timing expectations for the fixed scenarios.
module tb_uart_tx;

    localparam int DBIT    = 8;
    localparam int SB_TICK = 16;
`ifdef UART_TX_PARITY_EN
    localparam int PBITS   = 1;
`else
    localparam int PBITS   = 0;
`endif
    localparam int FRAME_TICKS = 16 * (1 + DBIT + PBITS) + SB_TICK;

    logic            clk = 1'b0;
    logic            rst;
    logic            s_tick = 1'b0;
    logic            tx_start;
    logic [DBIT-1:0] din;
    logic            tx;
    logic            tx_busy;
    logic            tx_done_tick;

    int n_chk  = 0;
    int n_err  = 0;
    int n_done = 0;
    bit chk_en = 1'b0;

    uart_tx #(.DBIT(DBIT), .SB_TICK(SB_TICK)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_tick       (s_tick),
        .tx_start     (tx_start),
        .din          (din),
        .tx           (tx),
        .tx_busy      (tx_busy),
        .tx_done_tick (tx_done_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // Tick source: 0 = every clock, 1 = one per tick_period clocks, 2 = random ~1 in 4.
    int tick_mode   = 0;
    int tick_period = 1;
    int tick_cnt    = 0;
    always @(posedge clk) begin
        #1;
        case (tick_mode)
            0: s_tick = 1'b1;
            1: begin
                s_tick   = (tick_cnt >= tick_period - 1);
                tick_cnt = (tick_cnt >= tick_period - 1) ? 0 : tick_cnt + 1;
            end
            default: s_tick = ($urandom_range(0, 3) == 0);
        endcase
    end

    // Frame model: position in ticks within the current frame.
    bit              m_active = 1'b0;
    int              m_pos    = 0;
    logic [DBIT-1:0] m_data   = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_active = 1'b0;
        end else if (m_active) begin
            if (s_tick) begin
                m_pos++;
                if (m_pos == FRAME_TICKS) m_active = 1'b0;
            end
        end else if (tx_start) begin
            m_active = 1'b1;
            m_pos    = 0;
            m_data   = din;
        end
    end

    function automatic logic exp_tx();
        if (!m_active)                         return 1'b1;
        if (m_pos < 16)                        return 1'b0;
        if (m_pos < 16 * (1 + DBIT))           return m_data[(m_pos - 16) / 16];
        if (PBITS == 1 && m_pos < 16 * (2 + DBIT)) return ^m_data;
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("cycle{tx,busy,done}",
                  {29'd0, tx, tx_busy, tx_done_tick},
                  {29'd0, exp_tx(), m_active,
                   (m_active && s_tick && !rst && m_pos == FRAME_TICKS - 1)});
        end
        if (tx_done_tick === 1'b1) n_done++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DBIT-1:0] b);
        tx_start = 1'b1;
        din      = b;
        step();
        tx_start = 1'b0;
        din      = DBIT'($urandom);
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (tx_busy !== 1'b0 && n < limit) begin
            step();
            n++;
        end
        check("idle_within_budget", {31'd0, tx_busy}, 32'd0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         done_at, d0, nt, t0, d1;
        int         tr[8];
        logic [9:0] cap;
        logic       b160, b161;

        rst = 1'b1;
        tx_start = 1'b0;
        din = '0;
        step();
        chk_en = 1'b1;
        repeat (2) step();
        @(negedge clk);
        check("reset_tx",   {31'd0, tx},           32'd1);
        check("reset_busy", {31'd0, tx_busy},      32'd0);
        check("reset_done", {31'd0, tx_done_tick}, 32'd0);
        step();
        rst = 1'b0;
        repeat (3) step();

        // Single 0xA5 with s_tick every clock.
        tick_mode = 0;
        wait_idle(50);
        send(8'hA5);
        done_at = -1; cap = '0; b160 = 1'b0; b161 = 1'b1;
        for (int i = 1; i <= 170; i++) begin
            @(negedge clk);
            if (tx_done_tick && done_at < 0) done_at = i;
            if (i % 16 == 8 && i / 16 < 10) cap[i / 16] = tx;
            if (i == 160) b160 = tx_busy;
            if (i == 161) b161 = tx_busy;
        end
        check("a5_bits",     {22'd0, cap},  32'h34A);
        check("a5_done_cyc", done_at,       32'd160);
        check("a5_busy_160", {31'd0, b160}, 32'd1);
        check("a5_busy_161", {31'd0, b161}, 32'd0);
        step();

        // Sparse ticks: one per 163 clocks, 0x3C.
        tick_mode = 1; tick_period = 163;
        wait_idle(50);
        send(8'h3C);
        nt = 0; done_at = -1; t0 = 1;
        for (int i = 1; i <= 30000; i++) begin
            @(negedge clk);
            if (tx !== t0[0]) begin
                if (nt < 8) tr[nt] = i;
                nt++;
                t0 = {31'd0, tx};
            end
            if (tx_done_tick) begin
                done_at = i;
                break;
            end
        end
        check("sparse_edges",    nt,                32'd4);
        check("sparse_run_1111", tr[2] - tr[1],     32'd10432);
        check("sparse_run_00",   tr[3] - tr[2],     32'd5216);
        check("sparse_stop",     done_at - tr[3],   32'd2607);
        step();

        // Request while busy is ignored.
        tick_mode = 2;
        wait_idle(50);
        d0 = n_done;
        send(8'h00);
        repeat ($urandom_range(100, 300)) step();
        check("busy_mid", {31'd0, tx_busy}, 32'd1);
        tx_start = 1'b1; din = 8'hFF;
        step();
        tx_start = 1'b0;
        wait_idle(4000);
        repeat (3) step();
        check("busy_one_done", n_done - d0, 32'd1);

        // Back-to-back with tx_start held high.
        tick_mode = 0;
        wait_idle(50);
        tx_start = 1'b1; din = 8'h81;
        step();
        din = 8'h42;
        d1 = -1; t0 = -1;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (d1 < 0 && tx_done_tick) d1 = i;
            else if (d1 >= 0 && tx === 1'b0) begin
                t0 = i;
                break;
            end
        end
        check("b2b_gap", t0 - d1, 32'd2);
        step();
        tx_start = 1'b0;
        wait_idle(400);

        // Reset during DATA bit 3.
        send(8'h96);
        repeat (69) step();
        d0 = n_done;
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_tx",      {31'd0, tx},           32'd1);
        check("rst_busy",    {31'd0, tx_busy},      32'd0);
        check("rst_done",    {31'd0, tx_done_tick}, 32'd0);
        check("rst_no_done", n_done - d0,           32'd0);
        step();
        send(8'h55);
        wait_idle(400);

`ifdef UART_TX_PARITY_EN
        // Parity frame: 0x07 has odd weight, so the parity bit is 1.
        step();
        send(8'h07);
        done_at = -1; b160 = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (tx_done_tick && done_at < 0) done_at = i;
            if (i == 152) b160 = tx;
        end
        check("par_bit",     {31'd0, b160}, 32'd1);
        check("par_done_cyc", done_at,      32'd176);
        step();
`endif

        // Random frames, random tick patterns and gaps.
        for (int f = 0; f < 8; f++) begin
            tick_mode = ($urandom_range(0, 1) == 0) ? 0 : 2;
            wait_idle(4000);
            repeat ($urandom_range(0, 5)) step();
            send(DBIT'($urandom));
        end
        wait_idle(4000);
        repeat (5) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
